// File: rtl/z80_io_master_if.sv
// Bus bundle for z80_io_master: the RISC-V register window on one side and
// the Z80 I/O initiator pins on the other.
interface z80_io_master_if;
    logic       io_valid;
    logic [3:0] rv_adr;
    logic       rv_wstr;
    logic [7:0] rv_wdata;
    logic [7:0] rv_rdata;
    logic       rv_ready;
    logic [7:0] z80adr;
    logic [7:0] z80do;
    logic [7:0] z80di;
    logic       z80_iorq_n;
    logic       z80_rd_n;
    logic       z80_wr_n;
    logic       z80_wait_n;

    modport master (
        input  io_valid, rv_adr, rv_wstr, rv_wdata, z80di, z80_wait_n,
        output rv_rdata, rv_ready, z80adr, z80do, z80_iorq_n, z80_rd_n, z80_wr_n
    );

    modport slave (
        output io_valid, rv_adr, rv_wstr, rv_wdata, z80di, z80_wait_n,
        input  rv_rdata, rv_ready, z80adr, z80do, z80_iorq_n, z80_rd_n, z80_wr_n
    );
endinterface

// File: rtl/z80_io_master.sv
// Firmware-driven Z80 I/O bus initiator: register window loads ADDR/WDATA,
// a CMD write launches one T1/T2/TWA/TW*/T3 I/O cycle with wait and timeout.
module z80_io_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  TIMEOUT_RDATA  = 8'hFF
) (
    input logic            clk,
    input logic            reset,
    z80_io_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t     state, state_nxt;
    logic [7:0] addr_q, wdata_q, rdata_q, wcnt;
    logic [7:0] z80adr_q, z80do_q, rv_rdata_q, rd_mux;
    logic       is_write, done, timeout, cmd_dropped, rv_ready_q;
    logic       acc, wr_acc, cmd_wr, busy;
    logic       strobe_on, cyc_end, cyc_abort, wcnt_inc;

    // An access is accepted on the edge where rv_ready rises, so a held
    // io_valid only produces one effect per pulse.
    assign acc    = bus.io_valid && !rv_ready_q;
    assign wr_acc = acc && bus.rv_wstr;
    assign cmd_wr = wr_acc && (bus.rv_adr == 4'd2);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        strobe_on = 1'b0;
        cyc_end   = 1'b0;
        cyc_abort = 1'b0;
        wcnt_inc  = 1'b0;
        case (state)
            S_IDLE: if (cmd_wr) state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2: begin
                strobe_on = 1'b1;
                state_nxt = S_TWA;
            end
            S_TWA: begin
                strobe_on = 1'b1;
                state_nxt = S_TW;
            end
            S_TW: begin
                strobe_on = 1'b1;
                if (bus.z80_wait_n) begin
                    state_nxt = S_T3;
                end else if (wcnt + 8'd1 == TMO) begin
                    cyc_abort = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            S_T3: begin
                strobe_on = 1'b1;
                cyc_end   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 8'h00;
        case (bus.rv_adr)
            4'd0: rd_mux = addr_q;
            4'd1: rd_mux = wdata_q;
            4'd3: rd_mux = {4'b0000, cmd_dropped, timeout, done, busy};
            4'd4: rd_mux = rdata_q;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rv_ready_q  <= 1'b0;
            rv_rdata_q  <= 8'h00;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            z80adr_q    <= 8'h00;
            z80do_q     <= 8'h00;
            wcnt        <= 8'h00;
            is_write    <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            rv_ready_q <= acc;
            if (acc) rv_rdata_q <= rd_mux;
            if (wr_acc && bus.rv_adr == 4'd0) addr_q  <= bus.rv_wdata;
            if (wr_acc && bus.rv_adr == 4'd1) wdata_q <= bus.rv_wdata;
            // Bus address/data are frozen here so register writes during a
            // cycle only affect the next one.
            if (cmd_wr) begin
                if (busy) begin
                    cmd_dropped <= 1'b1;
                end else begin
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                    cmd_dropped <= 1'b0;
                    is_write    <= bus.rv_wdata[0];
                    z80adr_q    <= addr_q;
                    z80do_q     <= wdata_q;
                end
            end
            if (state == S_T1)  wcnt <= 8'h00;
            else if (wcnt_inc)  wcnt <= wcnt + 8'd1;
            if (cyc_end) begin
                done <= 1'b1;
                if (!is_write) rdata_q <= bus.z80di;
            end
            if (cyc_abort) begin
                timeout <= 1'b1;
                if (!is_write) rdata_q <= TIMEOUT_RDATA;
            end
        end
    end

    assign bus.rv_ready   = rv_ready_q;
    assign bus.rv_rdata   = rv_rdata_q;
    assign bus.z80adr     = z80adr_q;
    assign bus.z80do      = z80do_q;
    assign bus.z80_iorq_n = !strobe_on;
    assign bus.z80_rd_n   = !(strobe_on && !is_write);
    assign bus.z80_wr_n   = !(strobe_on && is_write);
endmodule

// File: tb/tb_z80_io_master.sv
// Bench for z80_io_master: register-window vector table, hand-written bus
// sequences and randomized I/O cycles against a cycle-count model.
module tb_z80_io_master;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80_io_master_if bus ();
    z80_io_master dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic       wr;
        logic [3:0] adr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [17];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rdata;
    logic [7:0] r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rv_access(input logic wr, input logic [3:0] adr, input logic [7:0] wd,
                             output logic [7:0] rd);
        bit got;
        got = 0;
        bus.io_valid = 1'b1;
        bus.rv_wstr  = wr;
        bus.rv_adr   = adr;
        bus.rv_wdata = wd;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.rv_ready) begin
                got = 1;
                break;
            end
        end
        bus.io_valid = 1'b0;
        rd = bus.rv_rdata;
        if (!got) fail_now("rv_ready_wait");
    endtask

    // Model: T1 then strobes low for T2, TWA, (k+1) TW, T3; k >= TMO low TW
    // cycles aborts after TMO TW cycles with T3 skipped.
    task automatic run_cycle(input logic wr, input logic [7:0] a, input logic [7:0] d,
                             input int k, input logic [7:0] di, input int inj,
                             input string tag);
        int c, low, rdl, wrl, first_low, exp_low;
        bit fin, tmo;
        logic [7:0] rr;
        bus.z80di = di;
        bus.z80_wait_n = 1'b1;
        rv_access(1'b1, 4'd0, a, rr);
        rv_access(1'b1, 4'd1, d, rr);
        rv_access(1'b1, 4'd2, {7'd0, wr}, rr);
        chk({tag, "_adr_t1"}, bus.z80adr, a);
        chk({tag, "_do_t1"}, bus.z80do, d);
        c = 1; low = 0; rdl = 0; wrl = 0; first_low = 0; fin = 0;
        while (!fin && c < TMO + 40) begin
            bus.z80_wait_n = !(c >= 4 && c < 4 + k);
            if (inj != 0 && c == inj) begin
                bus.io_valid = 1'b1;
                bus.rv_wstr  = 1'b1;
                bus.rv_adr   = 4'd2;
                bus.rv_wdata = 8'h01;
            end
            if (inj != 0 && c == inj + 1) bus.io_valid = 1'b0;
            if (!bus.z80_iorq_n) begin
                low++;
                if (first_low == 0) first_low = c;
            end
            if (!bus.z80_rd_n) rdl++;
            if (!bus.z80_wr_n) wrl++;
            if (c > 1 && bus.z80_iorq_n) fin = 1;
            else begin
                step();
                c++;
            end
        end
        bus.z80_wait_n = 1'b1;
        if (!fin) fail_now({tag, "_cycle_end"});
        tmo = (k >= TMO);
        exp_low = tmo ? 2 + TMO : 4 + k;
        if (!wr) exp_rdata = tmo ? 8'hFF : di;
        chk({tag, "_low_cnt"}, low, exp_low);
        chk({tag, "_first_low"}, first_low, 2);
        chk({tag, "_rd_cnt"}, rdl, wr ? 0 : exp_low);
        chk({tag, "_wr_cnt"}, wrl, wr ? exp_low : 0);
        rv_access(1'b0, 4'd3, 8'h00, rr);
        chk({tag, "_status"}, rr, (tmo ? 4 : 2) | (inj != 0 ? 8 : 0));
        rv_access(1'b0, 4'd4, 8'h00, rr);
        chk({tag, "_rdata"}, rr, exp_rdata);
        chk({tag, "_adr_hold"}, bus.z80adr, a);
        chk({tag, "_do_hold"}, bus.z80do, d);
        chk({tag, "_idle_strobes"}, {bus.z80_iorq_n, bus.z80_rd_n, bus.z80_wr_n}, 3'b111);
    endtask

    initial begin
        int n;
        bus.io_valid = 1'b0;
        bus.rv_adr = 4'd0;
        bus.rv_wstr = 1'b0;
        bus.rv_wdata = 8'h00;
        bus.z80di = 8'h00;
        bus.z80_wait_n = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_strobes", {bus.z80_iorq_n, bus.z80_rd_n, bus.z80_wr_n}, 3'b111);
        chk("rst_adr", bus.z80adr, 8'h00);
        chk("rst_do", bus.z80do, 8'h00);
        chk("rst_ready", bus.rv_ready, 1'b0);
        chk("rst_rdata", bus.rv_rdata, 8'h00);
        reset = 1'b0;
        exp_rdata = 8'h00;

        tbl[0]  = '{1'b0, 4'd0,  8'h00, 8'h00};
        tbl[1]  = '{1'b0, 4'd1,  8'h00, 8'h00};
        tbl[2]  = '{1'b0, 4'd3,  8'h00, 8'h00};
        tbl[3]  = '{1'b0, 4'd4,  8'h00, 8'h00};
        tbl[4]  = '{1'b1, 4'd0,  8'h3C, 8'h00};
        tbl[5]  = '{1'b1, 4'd1,  8'hC3, 8'h00};
        tbl[6]  = '{1'b0, 4'd0,  8'h00, 8'h3C};
        tbl[7]  = '{1'b0, 4'd1,  8'h00, 8'hC3};
        tbl[8]  = '{1'b0, 4'd2,  8'h00, 8'h00};
        tbl[9]  = '{1'b1, 4'd9,  8'h77, 8'h00};
        tbl[10] = '{1'b0, 4'd9,  8'h00, 8'h00};
        tbl[11] = '{1'b1, 4'd3,  8'hFF, 8'h00};
        tbl[12] = '{1'b0, 4'd3,  8'h00, 8'h00};
        tbl[13] = '{1'b1, 4'd4,  8'h12, 8'h00};
        tbl[14] = '{1'b0, 4'd4,  8'h00, 8'h00};
        tbl[15] = '{1'b0, 4'd15, 8'h00, 8'h00};
        tbl[16] = '{1'b0, 4'd0,  8'h00, 8'h3C};
        for (int i = 0; i < 17; i++) begin
            rv_access(tbl[i].wr, tbl[i].adr, tbl[i].wd, r);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_adr%0d", i, tbl[i].adr), r, tbl[i].exp);
        end
        chk("tbl_no_cycle", bus.z80_iorq_n, 1'b1);

        // io_valid held three cycles: ready pulses on alternate cycles.
        step();
        bus.io_valid = 1'b1; bus.rv_wstr = 1'b0; bus.rv_adr = 4'd0;
        step();
        chk("b2b_rdy1", bus.rv_ready, 1'b1);
        chk("b2b_dat1", bus.rv_rdata, 8'h3C);
        bus.rv_adr = 4'd1;
        step();
        chk("b2b_rdy2", bus.rv_ready, 1'b0);
        step();
        chk("b2b_rdy3", bus.rv_ready, 1'b1);
        chk("b2b_dat3", bus.rv_rdata, 8'hC3);
        bus.io_valid = 1'b0;
        step();
        chk("b2b_rdy4", bus.rv_ready, 1'b0);

        run_cycle(1'b1, 8'h0A, 8'h55, 0,       8'h00, 0, "wr0");
        run_cycle(1'b0, 8'h11, 8'h22, 3,       8'hAA, 0, "rd3");
        run_cycle(1'b0, 8'h33, 8'h44, 1000,    8'h5A, 0, "tmo_rd");
        run_cycle(1'b1, 8'h66, 8'h77, 1000,    8'h5A, 0, "tmo_wr");
        run_cycle(1'b0, 8'h12, 8'h34, TMO - 1, 8'hC7, 0, "edge_rd");
        run_cycle(1'b1, 8'h0A, 8'h55, 0,       8'h00, 2, "drop_t2");
        run_cycle(1'b1, 8'h0B, 8'h56, 0,       8'h00, 0, "after_drop");

        // STATUS read during T2 sees busy only; done from the last cycle cleared.
        bus.z80di = 8'h3E;
        rv_access(1'b1, 4'd2, 8'h00, r);
        rv_access(1'b0, 4'd3, 8'h00, r);
        chk("busy_status", r, 8'h01);
        n = 0;
        while (!bus.z80_iorq_n && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail_now("busy_drain");
        exp_rdata = 8'h3E;

        // Reset in the middle of a wait-state cycle.
        bus.z80_wait_n = 1'b0;
        rv_access(1'b1, 4'd0, 8'h5A, r);
        rv_access(1'b1, 4'd2, 8'h00, r);
        repeat (5) step();
        chk("mid_rst_pre", bus.z80_iorq_n, 1'b0);
        reset = 1'b1;
        step();
        chk("mid_rst_strobes", {bus.z80_iorq_n, bus.z80_rd_n, bus.z80_wr_n}, 3'b111);
        chk("mid_rst_adr", bus.z80adr, 8'h00);
        chk("mid_rst_ready", bus.rv_ready, 1'b0);
        reset = 1'b0;
        bus.z80_wait_n = 1'b1;
        exp_rdata = 8'h00;
        rv_access(1'b0, 4'd3, 8'h00, r);
        chk("mid_rst_status", r, 8'h00);
        rv_access(1'b0, 4'd0, 8'h00, r);
        chk("mid_rst_addr_reg", r, 8'h00);
        rv_access(1'b0, 4'd4, 8'h00, r);
        chk("mid_rst_rdata_reg", r, 8'h00);
        run_cycle(1'b0, 8'h21, 8'h43, 1, 8'h99, 0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            int kk, sel, inj;
            sel = $urandom_range(0, 9);
            kk  = (sel < 8) ? sel : ((sel == 8) ? TMO - 1 : TMO + 3);
            inj = $urandom_range(0, 3);
            if (inj < 2) inj = 0;
            run_cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), kk,
                      8'($urandom), inj, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_io_master.md
Name: z80_io_master

Overview:
- RISC-V-controlled Z80 I/O bus initiator: the initiator end of the Z80 I/O protocol that cpm_io responds to.
- picorv32 loads address and data registers through a 16-entry register window, then writes a command register.
- The block then generates one Z80 I/O read or write cycle (T1/T2/TW*/T3) with WAIT_n support and a timeout.
- Used to exercise cpm_io's Z80 port without the T80 core, and to drive Z80-bus peripherals directly from firmware.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive TW cycles with wait_n low before the cycle is aborted. Range 1..255.
- TIMEOUT_RDATA, 8'hFF: value loaded into RDATA when a read cycle times out.

Ports:
- clk  input  1  system clock; one clock equals one Z80 T-state.
- reset  input  1  synchronous, active-high reset.
- io_valid  input  1  RISC-V access to this block's window, held until rv_ready.
- rv_adr  input  4  register index (mem_addr[5:2]).
- rv_wstr  input  1  1 = write access, 0 = read access.
- rv_wdata  input  8  write data (mem_wdata[7:0]).
- rv_rdata  output  8  registered read data; valid while rv_ready=1.
- rv_ready  output  1  one-cycle access-complete pulse.
- z80adr  output  8  Z80 I/O port address.
- z80do  output  8  data driven to the responder.
- z80di  input  8  data returned by the responder.
- z80_iorq_n  output  1  Z80 IORQ, active low.
- z80_rd_n  output  1  Z80 RD, active low.
- z80_wr_n  output  1  Z80 WR, active low.
- z80_wait_n  input  1  responder wait, active low (connects to cpm_io z80_io_ready).

Behaviour:
- Register map (rv_adr):
  - 0 ADDR: R/W, 8 bits.
  - 1 WDATA: R/W, 8 bits.
  - 2 CMD: write-only; bit0 = 1 for write cycle, 0 for read cycle; reads return 0.
  - 3 STATUS: read-only; bit0 busy, bit1 done, bit2 timeout, bit3 cmd_dropped; other bits 0.
  - 4 RDATA: read-only.
  - 5..15: reads return 0; writes ignored.
- RISC-V handshake:
  - rv_ready <= io_valid && !rv_ready, so every access completes in exactly 1 cycle, busy or not.
  - Register writes take effect on the rv_ready cycle's clock edge; rv_rdata is registered on the same edge.
  - An access costs exactly one write effect; a held io_valid does not repeat it.
- ADDR/WDATA writes while busy update the registers but do not affect the cycle in flight; z80adr and z80do are latched at T1 entry.
- CMD write while idle:
  - clears done, timeout and cmd_dropped; sets busy; next state T1.
- CMD write while busy: ignored; sets cmd_dropped.
- State machine, one clock per state:
  - IDLE: all strobes high; busy=0.
  - T1: z80adr=ADDR_latched; z80do=WDATA_latched; strobes high.
  - T2: iorq_n=0; rd_n=0 (read) or wr_n=0 (write).
  - TWA: automatic Z80 I/O wait state; strobes held low; wait_n not sampled.
  - TW: strobes low; wait_n sampled each cycle.
    - wait_n=1: go to T3.
    - wait_n=0: increment wcnt (8-bit, cleared at T1). When wcnt reaches TIMEOUT_CYCLES, abort: go to IDLE, set timeout, load RDATA=TIMEOUT_RDATA (read) or leave it unchanged (write).
  - T3: strobes low. On exit: capture RDATA<=z80di (read only), set done, go to IDLE with strobes high.
- Zero-wait latency: CMD edge at cycle n gives T1@n+1, T2@n+2, TWA@n+3, TW@n+4, T3@n+5, IDLE with done=1 at n+6. Each wait_n-low cycle adds 1.
- z80adr and z80do hold their value after the cycle until the next T1; they reset to 0.
- Reset, including mid-cycle: state=IDLE; all strobes=1; ADDR, WDATA, RDATA, z80adr, z80do = 0; busy, done, timeout, cmd_dropped = 0; rv_ready=0; rv_rdata=0. No partial cycle resumes.

Test Plan:
- Write cycle: ADDR=0x0A, WDATA=0x55, CMD=1, wait_n tied 1 -> iorq_n/wr_n low for exactly 3 cycles (T2, TWA, TW) plus T3 (4 total); z80adr=0x0A, z80do=0x55 from T1; done=1 at n+6; rd_n never low.
- Read cycle with wait_n low for 3 TW cycles, z80di=0xAA -> strobes low for 7 cycles; RDATA=0xAA; STATUS=0x02.
- wait_n held low -> abort after TIMEOUT_CYCLES TW cycles; strobes high next cycle; STATUS=0x04; RDATA=0xFF.
- CMD written during T2 of an active cycle -> only one cycle occurs; STATUS bit3=1 after completion; next CMD clears it.
- Reset asserted in TW -> strobes high on the next edge; STATUS=0; a following CMD runs a normal cycle.
- Back-to-back register reads with io_valid held 3 cycles -> rv_ready pulses alternate cycles; rv_rdata matches the register each pulse; a read of index 9 returns 0x00.
